huc_mem_arb: RTL and testbench
==============================

// Module: huc_mem_arb
//
// PURPOSE
// Shares the single cartridge memory port (ROM/RAM PSRAM) between two requesters.
// Requester 1 is the HuCard CPU bus decode (rom/ram MemCtrl strobes).
// Requester 2 is the MCU/DMA port used for menu loading and backup-RAM save.
// CPU accesses have priority; DMA gets guaranteed slots; single outstanding access to memory.
//
// PARAMETERS
// AW          24   memory address width
// DW          8    data width
// CPU_STREAK  4    max back-to-back CPU grants while DMA pending before DMA is forced a slot
// TMO         255  cycles to wait for mem_ack before abort (8-bit counter)
//
// PORTS
// clk         in   1   system clock
// rst         in   1   synchronous active-high reset
// cpu_ce      in   1   CPU access strobe (already synchronised to clk), level
// cpu_we      in   1   CPU write (sampled with cpu_ce rise)
// cpu_addr    in   AW  CPU memory address
// cpu_dati    in   DW  CPU write data
// cpu_dato    out  DW  CPU read data, held until next CPU read completes
// cpu_rdy     out  1   1 = last CPU access completed
// dma_req     in   1   DMA request, level, held until dma_ack
// dma_we      in   1   DMA write
// dma_addr    in   AW  DMA address
// dma_dati    in   DW  DMA write data
// dma_dato    out  DW  DMA read data, valid with dma_ack
// dma_ack     out  1   one-cycle pulse: DMA access done
// mem_req     out  1   memory request, level, held until mem_ack
// mem_we      out  1   memory write
// mem_addr    out  AW  memory address
// mem_dati    out  DW  memory write data
// mem_dato    in   DW  memory read data, valid with mem_ack
// mem_ack     in   1   one-cycle pulse: memory access done
// tmo_err     out  1   sticky: an access timed out; cleared only by rst
//
// BEHAVIOUR
// Reset: all outputs 0 except cpu_rdy=1; state IDLE; streak=0; pending flags clear.
// CPU edge detect: cpu_ce 0->1 sets cpu_pend and latches cpu_we/addr/dati, clears cpu_rdy.
// New cpu_ce rise while cpu_pend set: overwrites latch (last request wins), no error.
// States: IDLE, CPU_ACC, DMA_ACC.
//  IDLE: cpu_pend && !(dma_req && streak==CPU_STREAK) -> CPU_ACC, streak++ (saturating).
//        else dma_req -> DMA_ACC, streak=0. Grant decision takes 1 cycle.
//        dma_req low -> streak=0.
//  CPU_ACC: mem_req=1, mem_* from CPU latch. On mem_ack: cpu_dato<=mem_dato if read,
//        cpu_pend=0, cpu_rdy=1, -> IDLE. Same-cycle new cpu_ce rise re-arms cpu_pend.
//  DMA_ACC: mem_req=1, mem_* from dma_* (inputs stable while req). On mem_ack:
//        dma_dato<=mem_dato, dma_ack=1 for exactly one cycle, -> IDLE.
//        DMA must drop or change dma_req the cycle after dma_ack;
//        arbiter ignores dma_req in the ack cycle.
// mem_req asserted the cycle after grant; deasserted the cycle after mem_ack.
// Never two accesses back-to-back without an IDLE cycle.
// Latency: CPU rise -> mem_req = 2 clk when idle; ack -> cpu_rdy = 1 clk.
// Timeout: counter resets on entry to CPU_ACC/DMA_ACC; at TMO cycles w/o mem_ack:
//        set tmo_err, complete access as if acked with data 8'hFF, -> IDLE.
// mem_ack in IDLE: ignored.
// Reset mid-access: mem_req drops next cycle; in-flight result discarded; no dma_ack.
//
// TESTING
// 1 CPU read addr 0x7F0123, mem_ack after 3 clk, data 0xA5 -> mem_req 2 clk after ce rise;
//   cpu_dato=0xA5; cpu_rdy=1.
// 2 dma_req + cpu_ce rise same cycle -> CPU_ACC first, DMA granted next; dma_ack single pulse.
// 3 DMA held, 6 CPU accesses back-to-back -> DMA slot after 4th CPU grant (CPU_STREAK=4).
// 4 DMA write 0x5A to 0x000010 -> mem_we=1, mem_dati=0x5A; dma_ack 1 clk after mem_ack.
// 5 No mem_ack for 255 clk -> tmo_err=1; cpu_dato=0xFF; cpu_rdy=1; next access proceeds.
// 6 rst during DMA_ACC -> mem_req=0 next clk; no dma_ack; all outputs at reset values.

Source files
------------

// File: rtl/huc_mem_arb_if.sv
// ---------------------------------------------------------------------------
// huc_mem_arb_if
// Bundles the three buses around the cartridge memory arbiter:
//   cpu_*  HuCard CPU bus decode: level strobe, address, write data, read
//          data back, ready flag
//   dma_*  MCU/DMA port: level request held until dma_ack, read data, ack
//   mem_*  the single PSRAM port: level request held until mem_ack
//   tmo_err sticky timeout flag
// The slave modport is the arbiter's view. The master modport is the view
// of everything around it (the CPU decode, the DMA engine and the memory).
// ---------------------------------------------------------------------------
interface huc_mem_arb_if #(
  parameter int AW = 24,
  parameter int DW = 8
);
  logic          cpu_ce;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_dati;
  logic [DW-1:0] cpu_dato;
  logic          cpu_rdy;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_dati;
  logic [DW-1:0] dma_dato;
  logic          dma_ack;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dati;
  logic [DW-1:0] mem_dato;
  logic          mem_ack;

  logic          tmo_err;

  modport slave (
    input  cpu_ce, cpu_we, cpu_addr, cpu_dati,
    output cpu_dato, cpu_rdy,
    input  dma_req, dma_we, dma_addr, dma_dati,
    output dma_dato, dma_ack,
    output mem_req, mem_we, mem_addr, mem_dati,
    input  mem_dato, mem_ack,
    output tmo_err
  );

  modport master (
    output cpu_ce, cpu_we, cpu_addr, cpu_dati,
    input  cpu_dato, cpu_rdy,
    output dma_req, dma_we, dma_addr, dma_dati,
    input  dma_dato, dma_ack,
    input  mem_req, mem_we, mem_addr, mem_dati,
    output mem_dato, mem_ack,
    input  tmo_err
  );
endinterface

// File: rtl/huc_mem_arb.sv
// ---------------------------------------------------------------------------
// huc_mem_arb
// Shares the single cartridge memory port between the HuCard CPU bus decode
// and the MCU/DMA port. The CPU has priority. A DMA request that is kept
// waiting is forced a slot after CPU_STREAK back-to-back CPU grants. Only one
// access is outstanding to memory at a time, and every access is followed by
// at least one IDLE cycle.
//
// Ports
//   clk, rst  system clock, synchronous active-high reset
//   bus       huc_mem_arb_if.slave:
//     cpu_ce/we/addr/dati in; cpu_dato, cpu_rdy out
//     dma_req/we/addr/dati in; dma_dato, dma_ack out
//     mem_req/we/addr/dati out; mem_dato, mem_ack in
//     tmo_err out (sticky until rst)
//
// Parameters
//   AW, DW      address and data widths
//   CPU_STREAK  CPU grants allowed in a row while DMA waits
//   TMO         cycles an access may wait for mem_ack (1..256)
// ---------------------------------------------------------------------------
module huc_mem_arb #(
  parameter int AW         = 24,
  parameter int DW         = 8,
  parameter int CPU_STREAK = 4,
  parameter int TMO        = 255
) (
  input  logic           clk,
  input  logic           rst,
  huc_mem_arb_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, CPU_ACC, DMA_ACC} state_t;

  localparam int            SW         = (CPU_STREAK < 1) ? 1 : $clog2(CPU_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(CPU_STREAK);
  localparam logic [7:0]    TMO_LAST   = 8'(TMO - 1);
  localparam logic [DW-1:0] TMO_DATA   = {DW{1'b1}};

  state_t        state_q,      state_d;
  logic [SW-1:0] streak_q,     streak_d;
  logic [7:0]    tmo_cnt_q,    tmo_cnt_d;

  logic          cpu_ce_q,     cpu_ce_d;
  logic          cpu_pend_q,   cpu_pend_d;
  logic          cpu_rearm_q,  cpu_rearm_d;
  logic          cpu_we_l_q,   cpu_we_l_d;
  logic [AW-1:0] cpu_addr_l_q, cpu_addr_l_d;
  logic [DW-1:0] cpu_dati_l_q, cpu_dati_l_d;
  logic [DW-1:0] cpu_dato_q,   cpu_dato_d;
  logic          cpu_rdy_q,    cpu_rdy_d;

  logic          dma_req_q,    dma_req_d;
  logic [DW-1:0] dma_dato_q,   dma_dato_d;
  logic          dma_ack_q,    dma_ack_d;

  logic          mem_req_q,    mem_req_d;
  logic          mem_we_q,     mem_we_d;
  logic [AW-1:0] mem_addr_q,   mem_addr_d;
  logic [DW-1:0] mem_dati_q,   mem_dati_d;

  logic          tmo_err_q,    tmo_err_d;

  logic          cpu_rise;
  logic          dma_vld;
  logic          acc_tmo;
  logic          acc_done;
  logic [DW-1:0] acc_data;

  // Saturating increment of the CPU grant streak.
  function automatic logic [SW-1:0] streak_inc(input logic [SW-1:0] s);
    if (s == STREAK_MAX) return s;
    return s + SW'(1);
  endfunction

  assign cpu_rise = bus.cpu_ce && !cpu_ce_q;
  // The DMA request is seen one cycle late (it is registered, so it competes
  // on equal footing with a CPU strobe rising in the same cycle). It is
  // masked while dma_ack is high, because the DMA engine may still be holding
  // the request it has just been acked for.
  assign dma_vld  = dma_req_q && !dma_ack_q;
  assign acc_tmo  = (state_q != IDLE) && !bus.mem_ack && (tmo_cnt_q == TMO_LAST);
  assign acc_done = (state_q != IDLE) && (bus.mem_ack || acc_tmo);
  assign acc_data = bus.mem_ack ? bus.mem_dato : TMO_DATA;

  always_comb begin
    state_d      = state_q;
    streak_d     = streak_q;
    tmo_cnt_d    = tmo_cnt_q;
    cpu_ce_d     = bus.cpu_ce;
    cpu_pend_d   = cpu_pend_q;
    cpu_rearm_d  = cpu_rearm_q;
    cpu_we_l_d   = cpu_we_l_q;
    cpu_addr_l_d = cpu_addr_l_q;
    cpu_dati_l_d = cpu_dati_l_q;
    cpu_dato_d   = cpu_dato_q;
    cpu_rdy_d    = cpu_rdy_q;
    dma_req_d    = bus.dma_req && !dma_ack_q;
    dma_dato_d   = dma_dato_q;
    dma_ack_d    = 1'b0;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_dati_d   = mem_dati_q;
    tmo_err_d    = tmo_err_q || acc_tmo;

    // A new CPU strobe always overwrites the latch: the last request wins.
    if (cpu_rise) begin
      cpu_pend_d   = 1'b1;
      cpu_rdy_d    = 1'b0;
      cpu_we_l_d   = bus.cpu_we;
      cpu_addr_l_d = bus.cpu_addr;
      cpu_dati_l_d = bus.cpu_dati;
    end

    case (state_q)
      IDLE: begin
        if (cpu_pend_q && !(dma_vld && streak_q == STREAK_MAX)) begin
          state_d     = CPU_ACC;
          mem_req_d   = 1'b1;
          mem_we_d    = cpu_we_l_q;
          mem_addr_d  = cpu_addr_l_q;
          mem_dati_d  = cpu_dati_l_q;
          streak_d    = dma_vld ? streak_inc(streak_q) : '0;
          tmo_cnt_d   = '0;
          // The memory side holds its own copy of the request, so a strobe
          // arriving now is a fresh request that must survive this access.
          cpu_rearm_d = cpu_rise;
        end else if (dma_vld) begin
          state_d    = DMA_ACC;
          mem_req_d  = 1'b1;
          mem_we_d   = bus.dma_we;
          mem_addr_d = bus.dma_addr;
          mem_dati_d = bus.dma_dati;
          streak_d   = '0;
          tmo_cnt_d  = '0;
        end else begin
          streak_d = '0;
        end
      end

      CPU_ACC: begin
        tmo_cnt_d = tmo_cnt_q + 8'd1;
        if (cpu_rise) cpu_rearm_d = 1'b1;
        if (acc_done) begin
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          if (!mem_we_q) cpu_dato_d = acc_data;
          cpu_pend_d  = cpu_rise || cpu_rearm_q;
          cpu_rdy_d   = !(cpu_rise || cpu_rearm_q);
          cpu_rearm_d = 1'b0;
        end
      end

      DMA_ACC: begin
        tmo_cnt_d = tmo_cnt_q + 8'd1;
        if (acc_done) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          dma_dato_d = acc_data;
          dma_ack_d  = 1'b1;
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      streak_q     <= '0;
      tmo_cnt_q    <= '0;
      cpu_ce_q     <= 1'b0;
      cpu_pend_q   <= 1'b0;
      cpu_rearm_q  <= 1'b0;
      cpu_we_l_q   <= 1'b0;
      cpu_addr_l_q <= '0;
      cpu_dati_l_q <= '0;
      cpu_dato_q   <= '0;
      cpu_rdy_q    <= 1'b1;
      dma_req_q    <= 1'b0;
      dma_dato_q   <= '0;
      dma_ack_q    <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_dati_q   <= '0;
      tmo_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      streak_q     <= streak_d;
      tmo_cnt_q    <= tmo_cnt_d;
      cpu_ce_q     <= cpu_ce_d;
      cpu_pend_q   <= cpu_pend_d;
      cpu_rearm_q  <= cpu_rearm_d;
      cpu_we_l_q   <= cpu_we_l_d;
      cpu_addr_l_q <= cpu_addr_l_d;
      cpu_dati_l_q <= cpu_dati_l_d;
      cpu_dato_q   <= cpu_dato_d;
      cpu_rdy_q    <= cpu_rdy_d;
      dma_req_q    <= dma_req_d;
      dma_dato_q   <= dma_dato_d;
      dma_ack_q    <= dma_ack_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_dati_q   <= mem_dati_d;
      tmo_err_q    <= tmo_err_d;
    end
  end

  assign bus.cpu_dato = cpu_dato_q;
  assign bus.cpu_rdy  = cpu_rdy_q;
  assign bus.dma_dato = dma_dato_q;
  assign bus.dma_ack  = dma_ack_q;
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_dati = mem_dati_q;
  assign bus.tmo_err  = tmo_err_q;

endmodule

// File: tb/tb_huc_mem_arb.sv
// ---------------------------------------------------------------------------
// tb_huc_mem_arb
// Directed bench for huc_mem_arb: CPU read, CPU/DMA priority, DMA slot
// after a CPU streak, DMA write, access timeout and reset during a DMA access.
// ---------------------------------------------------------------------------
module tb_huc_mem_arb;

  logic clk;
  logic rst;
  int   nvec;
  int   nerr;

  huc_mem_arb_if #(.AW(24), .DW(8)) bus ();

  huc_mem_arb #(.AW(24), .DW(8), .CPU_STREAK(4), .TMO(255)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    nvec++; if (bus.mem_req !== 1'b0) begin nerr++; $display("FAIL rst_mem_req: got %0h want 0", bus.mem_req); end
    nvec++; if (bus.cpu_rdy !== 1'b1) begin nerr++; $display("FAIL rst_cpu_rdy: got %0h want 1", bus.cpu_rdy); end
    nvec++; if (bus.dma_ack !== 1'b0) begin nerr++; $display("FAIL rst_dma_ack: got %0h want 0", bus.dma_ack); end
    nvec++; if (bus.tmo_err !== 1'b0) begin nerr++; $display("FAIL rst_tmo_err: got %0h want 0", bus.tmo_err); end
    nvec++; if (bus.cpu_dato !== 8'h00) begin nerr++; $display("FAIL rst_cpu_dato: got %0h want 0", bus.cpu_dato); end
    nvec++; if (bus.mem_addr !== 24'h0) begin nerr++; $display("FAIL rst_mem_addr: got %0h want 0", bus.mem_addr); end
  endtask

  task automatic test_cpu_read();
    bus.cpu_ce = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 24'h7F0123;
    tick();
    nvec++; if (bus.mem_req !== 1'b0) begin nerr++; $display("FAIL t1_mem_req_early: got %0h want 0", bus.mem_req); end
    nvec++; if (bus.cpu_rdy !== 1'b0) begin nerr++; $display("FAIL t1_rdy_clear: got %0h want 0", bus.cpu_rdy); end
    bus.cpu_ce = 1'b0;
    tick();
    nvec++; if (bus.mem_req !== 1'b1) begin nerr++; $display("FAIL t1_mem_req: got %0h want 1", bus.mem_req); end
    nvec++; if (bus.mem_addr !== 24'h7F0123) begin nerr++; $display("FAIL t1_mem_addr: got %0h want 7f0123", bus.mem_addr); end
    nvec++; if (bus.mem_we !== 1'b0) begin nerr++; $display("FAIL t1_mem_we: got %0h want 0", bus.mem_we); end
    tick();
    tick();
    nvec++; if (bus.cpu_rdy !== 1'b0) begin nerr++; $display("FAIL t1_rdy_busy: got %0h want 0", bus.cpu_rdy); end
    bus.mem_ack = 1'b1; bus.mem_dato = 8'hA5;
    tick();
    bus.mem_ack = 1'b0;
    nvec++; if (bus.cpu_dato !== 8'hA5) begin nerr++; $display("FAIL t1_cpu_dato: got %0h want a5", bus.cpu_dato); end
    nvec++; if (bus.cpu_rdy !== 1'b1) begin nerr++; $display("FAIL t1_cpu_rdy: got %0h want 1", bus.cpu_rdy); end
    nvec++; if (bus.mem_req !== 1'b0) begin nerr++; $display("FAIL t1_mem_req_drop: got %0h want 0", bus.mem_req); end
  endtask

  task automatic test_priority();
    bus.cpu_ce = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 24'h000100;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 24'h000200;
    tick();
    bus.cpu_ce = 1'b0;
    tick();
    nvec++; if (bus.mem_addr !== 24'h000100 || bus.mem_req !== 1'b1) begin nerr++; $display("FAIL t2_cpu_first: got req %0h addr %0h want 1 000100", bus.mem_req, bus.mem_addr); end
    bus.mem_ack = 1'b1; bus.mem_dato = 8'h11;
    tick();
    bus.mem_ack = 1'b0;
    nvec++; if (bus.cpu_dato !== 8'h11) begin nerr++; $display("FAIL t2_cpu_dato: got %0h want 11", bus.cpu_dato); end
    nvec++; if (bus.mem_req !== 1'b0 || bus.dma_ack !== 1'b0) begin nerr++; $display("FAIL t2_idle_gap: got req %0h ack %0h want 0 0", bus.mem_req, bus.dma_ack); end
    tick();
    nvec++; if (bus.mem_addr !== 24'h000200 || bus.mem_req !== 1'b1) begin nerr++; $display("FAIL t2_dma_next: got req %0h addr %0h want 1 000200", bus.mem_req, bus.mem_addr); end
    bus.mem_ack = 1'b1; bus.mem_dato = 8'h22;
    tick();
    bus.mem_ack = 1'b0;
    nvec++; if (bus.dma_ack !== 1'b1) begin nerr++; $display("FAIL t2_dma_ack: got %0h want 1", bus.dma_ack); end
    nvec++; if (bus.dma_dato !== 8'h22) begin nerr++; $display("FAIL t2_dma_dato: got %0h want 22", bus.dma_dato); end
    tick();
    nvec++; if (bus.dma_ack !== 1'b0) begin nerr++; $display("FAIL t2_dma_ack_pulse: got %0h want 0", bus.dma_ack); end
    nvec++; if (bus.mem_req !== 1'b0) begin nerr++; $display("FAIL t2_ack_cycle_ignored: got %0h want 0", bus.mem_req); end
    bus.dma_req = 1'b0;
    tick();
    nvec++; if (bus.mem_req !== 1'b0) begin nerr++; $display("FAIL t2_no_regrant: got %0h want 0", bus.mem_req); end
  endtask

  task automatic test_cpu_streak();
    logic [23:0] exp_addr [7];
    int          n;
    int          cpu_issued;
    exp_addr = '{24'h000001, 24'h000002, 24'h000003, 24'h000004,
                 24'h000300, 24'h000005, 24'h000006};
    bus.cpu_ce = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 24'h000001;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 24'h000300;
    cpu_issued = 1;
    tick();
    bus.cpu_ce = 1'b0;
    for (int i = 0; i < 7; i++) begin
      n = 0;
      while (bus.mem_req !== 1'b1 && n < 10) begin
        tick();
        n++;
      end
      nvec++;
      if (bus.mem_req !== 1'b1) begin
        nerr++; $display("FAIL t3_grant_%0d: got no mem_req want grant within 10 clk", i);
      end else begin
        if (bus.mem_addr !== exp_addr[i]) begin nerr++; $display("FAIL t3_order_%0d: got addr %0h want %0h", i, bus.mem_addr, exp_addr[i]); end
        bus.mem_ack = 1'b1; bus.mem_dato = 8'(i);
        if (i != 4 && cpu_issued < 6) begin
          cpu_issued++;
          bus.cpu_ce = 1'b1; bus.cpu_addr = 24'(cpu_issued);
        end
        tick();
        bus.mem_ack = 1'b0; bus.cpu_ce = 1'b0;
        nvec++; if (bus.mem_req !== 1'b0) begin nerr++; $display("FAIL t3_gap_%0d: got mem_req %0h want 0", i, bus.mem_req); end
        if (i == 4) begin
          nvec++; if (bus.dma_ack !== 1'b1) begin nerr++; $display("FAIL t3_dma_ack: got %0h want 1", bus.dma_ack); end
          bus.dma_req = 1'b0;
        end
      end
    end
    tick();
    tick();
  endtask

  task automatic test_dma_write();
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 24'h000010; bus.dma_dati = 8'h5A;
    tick();
    nvec++; if (bus.mem_req !== 1'b0) begin nerr++; $display("FAIL t4_req_early: got %0h want 0", bus.mem_req); end
    tick();
    nvec++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1) begin nerr++; $display("FAIL t4_mem_we: got req %0h we %0h want 1 1", bus.mem_req, bus.mem_we); end
    nvec++; if (bus.mem_dati !== 8'h5A) begin nerr++; $display("FAIL t4_mem_dati: got %0h want 5a", bus.mem_dati); end
    nvec++; if (bus.mem_addr !== 24'h000010) begin nerr++; $display("FAIL t4_mem_addr: got %0h want 000010", bus.mem_addr); end
    nvec++; if (bus.dma_ack !== 1'b0) begin nerr++; $display("FAIL t4_ack_early: got %0h want 0", bus.dma_ack); end
    bus.mem_ack = 1'b1; bus.mem_dato = 8'h00;
    tick();
    bus.mem_ack = 1'b0;
    nvec++; if (bus.dma_ack !== 1'b1) begin nerr++; $display("FAIL t4_dma_ack: got %0h want 1", bus.dma_ack); end
    bus.dma_req = 1'b0; bus.dma_we = 1'b0;
    tick();
    nvec++; if (bus.dma_ack !== 1'b0) begin nerr++; $display("FAIL t4_ack_pulse: got %0h want 0", bus.dma_ack); end
  endtask

  task automatic test_timeout();
    logic held;
    bus.cpu_ce = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 24'h000555;
    tick();
    bus.cpu_ce = 1'b0;
    tick();
    nvec++; if (bus.mem_req !== 1'b1) begin nerr++; $display("FAIL t5_mem_req: got %0h want 1", bus.mem_req); end
    held = 1'b1;
    for (int i = 0; i < 254; i++) begin
      tick();
      if (bus.mem_req !== 1'b1 || bus.tmo_err !== 1'b0) held = 1'b0;
    end
    nvec++; if (held !== 1'b1) begin nerr++; $display("FAIL t5_early_abort: got held %0h want 1", held); end
    tick();
    nvec++; if (bus.tmo_err !== 1'b1) begin nerr++; $display("FAIL t5_tmo_err: got %0h want 1", bus.tmo_err); end
    nvec++; if (bus.cpu_dato !== 8'hFF) begin nerr++; $display("FAIL t5_cpu_dato: got %0h want ff", bus.cpu_dato); end
    nvec++; if (bus.cpu_rdy !== 1'b1 || bus.mem_req !== 1'b0) begin nerr++; $display("FAIL t5_complete: got rdy %0h req %0h want 1 0", bus.cpu_rdy, bus.mem_req); end
    bus.cpu_ce = 1'b1; bus.cpu_addr = 24'h000666;
    tick();
    bus.cpu_ce = 1'b0;
    tick();
    nvec++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 24'h000666) begin nerr++; $display("FAIL t5_next_req: got req %0h addr %0h want 1 000666", bus.mem_req, bus.mem_addr); end
    bus.mem_ack = 1'b1; bus.mem_dato = 8'h3C;
    tick();
    bus.mem_ack = 1'b0;
    nvec++; if (bus.cpu_dato !== 8'h3C) begin nerr++; $display("FAIL t5_next_dato: got %0h want 3c", bus.cpu_dato); end
    nvec++; if (bus.tmo_err !== 1'b1) begin nerr++; $display("FAIL t5_sticky: got %0h want 1", bus.tmo_err); end
  endtask

  task automatic test_reset_mid_dma();
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 24'h000777;
    tick();
    tick();
    nvec++; if (bus.mem_req !== 1'b1) begin nerr++; $display("FAIL t6_mem_req: got %0h want 1", bus.mem_req); end
    rst = 1'b1; bus.mem_ack = 1'b1; bus.mem_dato = 8'h99;
    tick();
    nvec++; if (bus.mem_req !== 1'b0) begin nerr++; $display("FAIL t6_req_drop: got %0h want 0", bus.mem_req); end
    nvec++; if (bus.dma_ack !== 1'b0) begin nerr++; $display("FAIL t6_no_ack: got %0h want 0", bus.dma_ack); end
    nvec++; if (bus.dma_dato !== 8'h00) begin nerr++; $display("FAIL t6_dma_dato: got %0h want 0", bus.dma_dato); end
    nvec++; if (bus.tmo_err !== 1'b0) begin nerr++; $display("FAIL t6_tmo_clr: got %0h want 0", bus.tmo_err); end
    nvec++; if (bus.cpu_rdy !== 1'b1 || bus.cpu_dato !== 8'h00) begin nerr++; $display("FAIL t6_cpu_outs: got rdy %0h dato %0h want 1 0", bus.cpu_rdy, bus.cpu_dato); end
    rst = 1'b0; bus.mem_ack = 1'b0; bus.dma_req = 1'b0;
    tick();
    nvec++; if (bus.dma_ack !== 1'b0 || bus.mem_req !== 1'b0) begin nerr++; $display("FAIL t6_after: got ack %0h req %0h want 0 0", bus.dma_ack, bus.mem_req); end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    rst = 1'b1;
    bus.cpu_ce = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_dati = '0;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_dati = '0;
    bus.mem_dato = '0; bus.mem_ack = 1'b0;
    test_reset();
    test_cpu_read();
    test_priority();
    test_cpu_streak();
    test_dma_write();
    test_timeout();
    test_reset_mid_dma();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
